uart_tx_multi: RTL
==================

UART_TX_MULTI -- requirements
Module: uart_tx_multi

Interface
REQ-001 Parameter WORD_BYTES, default 4, number of bytes per accepted word (1..8).
REQ-002 Parameter CLK_DIV, default 100, clock cycles per serial bit (>=2).
REQ-003 Parameter PARITY_EN, default 0; 1 = even parity bit appended after data bits.
REQ-004 Parameter STOP_BITS, default 1, number of stop bits (1 or 2).
REQ-005 clk_i  input  1  single clock; all state changes on rising edge.
REQ-006 rst_i  input  1  asynchronous, active-high reset.
REQ-007 stb_i  input  1  word strobe; transfer occurs when stb_i and rdy_o are both high at a rising edge.
REQ-008 data_i  input  8*WORD_BYTES  word to send; byte k = data_i[8k+7:8k].
REQ-009 sel_i  input  WORD_BYTES  byte enable mask; bit k set = send byte k.
REQ-010 xstb_i  input  1  flow-control strobe qualifying xon_i/xoff_i.
REQ-011 xon_i  input  1  resume request, valid with xstb_i.
REQ-012 xoff_i  input  1  pause request, valid with xstb_i.
REQ-013 rdy_o  output  1  high when a new word can be accepted.
REQ-014 tx_o  output  1  serial line, idle high.
REQ-015 paused_o  output  1  current flow-control pause flag.

Function
REQ-016 States: IDLE, WAIT, START, DATA, PARITY, STOP; rdy_o is high only in IDLE.
REQ-017 On transfer, data_i and sel_i are latched; later input changes do not affect the word in flight.
REQ-018 Enabled bytes are sent in ascending index order; disabled bytes are skipped with zero extra cycles.
REQ-019 Transfer with sel_i all-zero: no frame sent, tx_o stays high, rdy_o low for exactly one cycle.
REQ-020 Each frame: one start bit (0), 8 data bits LSB first, parity bit if PARITY_EN, STOP_BITS stop bits (1).
REQ-021 Every bit holds tx_o for exactly CLK_DIV cycles; bit counter is clog2(CLK_DIV) wide and wraps to 0 at CLK_DIV-1.
REQ-022 Parity bit = XOR of the 8 data bits (even parity).
REQ-023 When the first enabled byte may start, tx_o drives the start bit from the cycle after the transfer edge.
REQ-024 Consecutive enabled bytes are back-to-back: next start bit follows the last stop bit with no idle gap.
REQ-025 After the last enabled byte's final stop bit, the FSM returns to IDLE and rdy_o rises the next cycle.
REQ-026 xstb_i with xoff_i=1, xon_i=0 sets paused; xstb_i with xon_i=1, xoff_i=0 clears paused; update visible on paused_o the next cycle.
REQ-027 xstb_i with both or neither of xon_i/xoff_i high leaves paused unchanged; xon_i/xoff_i without xstb_i are ignored.
REQ-028 Pause acts at frame boundaries only: a frame in progress always completes, including stop bits.
REQ-029 While paused, before any pending byte starts, the FSM sits in WAIT with tx_o high; it leaves WAIT the cycle after paused clears.
REQ-030 A transfer is accepted in IDLE even while paused; the word then waits in WAIT.
REQ-031 paused flag and the byte queue are independent: xon/xoff during IDLE only updates the flag.

Reset
REQ-032 While rst_i is high: state IDLE, tx_o=1, rdy_o=1, paused_o=0, counters and latched word cleared.
REQ-033 Reset asserted mid-frame aborts the frame immediately (asynchronously); tx_o returns high without waiting for a clock.
REQ-034 First transfer is accepted on the first rising edge after rst_i deasserts.

Verification (CLK_DIV=4, WORD_BYTES=4, PARITY_EN=0, STOP_BITS=1 unless stated)
REQ-035 data_i=0x000000A5, sel_i=0001 -> tx_o 0,1,0,1,0,0,1,0,1,1 each 4 cycles; rdy_o low 40 cycles, high next.
REQ-036 data_i=0x44332211, sel_i=1010 -> frames 0x22 then 0x44 back-to-back, 80 cycles total; bytes 0x11/0x33 absent.
REQ-037 sel_i=0000 -> tx_o constant 1, rdy_o low exactly 1 cycle.
REQ-038 sel_i=1111, xoff pulse during byte 1 -> byte 1 completes, tx_o high in WAIT; xon pulse -> byte 2 starts next cycle; all 4 bytes correct.
REQ-039 PARITY_EN=1, STOP_BITS=2, byte 0x07 -> parity bit 1, two stop bits, frame length 48 cycles.
REQ-040 rst_i asserted at cycle 10 of a frame -> tx_o=1 and rdy_o=1 before next edge; new transfer after release sent correctly.

Source files
------------

// File: rtl/uart_tx_multi.sv
// Multi-byte UART transmitter: accepts one word, sends its enabled bytes as
// back-to-back 8-bit frames, with XON/XOFF pausing at frame boundaries.
module uart_tx_multi #(
    parameter int WORD_BYTES = 4,
    parameter int CLK_DIV    = 100,
    parameter int PARITY_EN  = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    stb_i,
    input  logic [8*WORD_BYTES-1:0] data_i,
    input  logic [WORD_BYTES-1:0]   sel_i,
    input  logic                    xstb_i,
    input  logic                    xon_i,
    input  logic                    xoff_i,
    output logic                    rdy_o,
    output logic                    tx_o,
    output logic                    paused_o
);

    localparam int            CW       = $clog2(CLK_DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, WAIT, START, DATA, PARITY, STOP} state_t;

    state_t                  state;
    logic [CW-1:0]           div_cnt;
    logic [2:0]              bit_idx;
    logic                    stop_cnt;
    logic [8*WORD_BYTES-1:0] word_q;
    logic [WORD_BYTES-1:0]   pend_q;
    logic [7:0]              byte_q;
    logic                    tx_q;
    logic                    rdy_q;
    logic                    paused_q;

    logic [8*WORD_BYTES-1:0] src_word;
    logic [WORD_BYTES-1:0]   src_mask;
    logic [WORD_BYTES-1:0]   rest_mask;
    logic [7:0]              first_byte;
    logic                    bit_end;

    // In IDLE the launch byte comes straight from the inputs so the start bit
    // can appear the cycle after the transfer edge.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        src_word   = (state == IDLE) ? data_i : word_q;
        src_mask   = (state == IDLE) ? sel_i  : pend_q;
        first_byte = '0;
        for (int k = WORD_BYTES - 1; k >= 0; k--) begin
            if (src_mask[k]) first_byte = src_word[8*k +: 8];
        end
        rest_mask  = src_mask & (src_mask - WORD_BYTES'(1));
    end

    assign bit_end = (div_cnt == DIV_LAST);

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // sees the pre-edge values of the others regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            word_q   <= '0;
            pend_q   <= '0;
            byte_q   <= '0;
            tx_q     <= 1'b1;
            rdy_q    <= 1'b1;
            paused_q <= 1'b0;
        end else begin
            if (xstb_i && xoff_i && !xon_i)      paused_q <= 1'b1;
            else if (xstb_i && xon_i && !xoff_i) paused_q <= 1'b0;

            if (state inside {START, DATA, PARITY, STOP})
                div_cnt <= bit_end ? '0 : div_cnt + CW'(1);
            else
                div_cnt <= '0;

            case (state)
                IDLE: if (stb_i) begin
                    word_q <= data_i;
                    rdy_q  <= 1'b0;
                    if (sel_i != '0 && !paused_q) begin
                        state  <= START;
                        tx_q   <= 1'b0;
                        byte_q <= first_byte;
                        pend_q <= rest_mask;
                    end else begin
                        state  <= WAIT;
                        pend_q <= sel_i;
                    end
                end
                WAIT: if (pend_q == '0) begin
                    state <= IDLE;
                    rdy_q <= 1'b1;
                end else if (!paused_q) begin
                    state  <= START;
                    tx_q   <= 1'b0;
                    byte_q <= first_byte;
                    pend_q <= rest_mask;
                end
                START: if (bit_end) begin
                    state   <= DATA;
                    tx_q    <= byte_q[0];
                    bit_idx <= '0;
                end
                DATA: if (bit_end) begin
                    if (bit_idx == 3'd7) begin
                        if (PARITY_EN != 0) begin
                            state <= PARITY;
                            tx_q  <= ^byte_q;
                        end else begin
                            state    <= STOP;
                            tx_q     <= 1'b1;
                            stop_cnt <= 1'b0;
                        end
                    end else begin
                        bit_idx <= bit_idx + 3'd1;
                        tx_q    <= byte_q[bit_idx + 3'd1];
                    end
                end
                PARITY: if (bit_end) begin
                    state    <= STOP;
                    tx_q     <= 1'b1;
                    stop_cnt <= 1'b0;
                end
                // Frame boundary: the only place a pause can hold back the next byte.
                STOP: if (bit_end) begin
                    if (STOP_BITS == 2 && !stop_cnt) begin
                        stop_cnt <= 1'b1;
                    end else if (pend_q == '0) begin
                        state <= IDLE;
                        rdy_q <= 1'b1;
                    end else if (paused_q) begin
                        state <= WAIT;
                    end else begin
                        state  <= START;
                        tx_q   <= 1'b0;
                        byte_q <= first_byte;
                        pend_q <= rest_mask;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rdy_o    = rdy_q;
    assign tx_o     = tx_q;
    assign paused_o = paused_q;

endmodule
